// File: rtl/smc_seq_if.sv
// Beat/result bus for smc_seq: transistor beats in, one weighted-sum result out.
interface smc_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] W;
  logic [2:0] V_GS;
  logic [2:0] V_DS;
  logic [1:0] mode;
  logic       out_valid;
  logic [9:0] out_n;

  // Source of beats, sink of results.
  modport master (
    output in_valid, W, V_GS, V_DS, mode,
    input  in_ready, out_valid, out_n
  );

  // The sequencer itself.
  modport slave (
    input  in_valid, W, V_GS, V_DS, mode,
    output in_ready, out_valid, out_n
  );
endinterface

// File: rtl/smc_seq.sv
// smc_seq: collects six transistor beats, converts each to an ID or gm value,
// keeps them sorted, then emits a weighted sum of the largest or smallest three.
module smc_seq (
  input logic       clk,
  input logic       rst,
  smc_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, SUM, OUT} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] beat_cnt;
  logic [1:0] mode_q;
  logic [6:0] n_q   [6];
  logic [6:0] n_ins [6];
  logic [9:0] out_q;
  logic       accept;

  // Shared per-beat compute unit signals.
  logic [2:0] g;
  logic       is_tri;
  logic       use_id;
  logic [8:0] w9;
  logic [8:0] g9;
  logic [8:0] vds9;
  logic [8:0] prod;
  logic [6:0] value;

  // Result path signals.
  logic [6:0] s0;
  logic [6:0] s1;
  logic [6:0] s2;
  logic [9:0] result;

  assign accept    = bus.in_valid & bus.in_ready;
  assign bus.out_n = out_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all clocked state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of process ordering.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: frame walks IDLE -> LOAD -> SUM -> OUT -> IDLE.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = LOAD;
      LOAD: if (accept && beat_cnt == 3'd5) state_nxt = SUM;
      SUM:  state_nxt = OUT;
      OUT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: handshake ready while collecting, strobe while presenting.
  always_comb begin
    bus.in_ready  = (state == IDLE) || (state == LOAD);
    bus.out_valid = (state == OUT);
  end

  // Per-beat value: beat 0 uses the incoming mode, later beats the latched one.
  always_comb begin
    g      = (bus.V_GS == 3'd0) ? 3'd0 : bus.V_GS - 3'd1;
    is_tri = g > bus.V_DS;
    use_id = (state == IDLE) ? bus.mode[0] : mode_q[0];
    w9     = {6'b0, bus.W};
    g9     = {6'b0, g};
    vds9   = {6'b0, bus.V_DS};
    prod   = '0;
    if (use_id) begin
      if (is_tri) prod = w9 * vds9 * ((g9 << 1) - vds9);
      else        prod = w9 * g9 * g9;
    end else begin
      if (is_tri) prod = 9'd2 * w9 * vds9;
      else        prod = 9'd2 * w9 * g9;
    end
    value = 7'(prod / 9'd3);
  end

  // Sorted insertion: each slot keeps, takes the new value, or takes its upper neighbour.
  always_comb begin
    n_ins[0] = (n_q[0] >= value) ? n_q[0] : value;
    for (int i = 1; i < 6; i++) begin
      if (n_q[i] >= value)        n_ins[i] = n_q[i];
      else if (n_q[i-1] >= value) n_ins[i] = value;
      else                        n_ins[i] = n_q[i-1];
    end
  end

  // Result selection and weighting from the latched mode.
  always_comb begin
    if (mode_q[1]) begin
      s0 = n_q[0]; s1 = n_q[1]; s2 = n_q[2];
    end else begin
      s0 = n_q[3]; s1 = n_q[4]; s2 = n_q[5];
    end
    if (mode_q[0])
      result = 10'd3 * {3'b0, s0} + 10'd4 * {3'b0, s1} + 10'd5 * {3'b0, s2};
    else
      result = {3'b0, s0} + {3'b0, s1} + {3'b0, s2};
  end

  // Datapath registers: beat count, latched mode, sorted array, held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      mode_q   <= '0;
      // NOTE: the sort array is six plain flops, not a RAM, so it takes the
      // async reset and starts every run from a known all-zero state.
      for (int i = 0; i < 6; i++) n_q[i] <= '0;
      out_q    <= '0;
    end else begin
      if (accept) begin
        if (state == IDLE) begin
          // Beat 0 starts a fresh frame: zero fillers sort to the bottom and
          // are the ones shifted out as real beats arrive.
          mode_q   <= bus.mode;
          beat_cnt <= 3'd1;
          n_q[0]   <= value;
          for (int i = 1; i < 6; i++) n_q[i] <= '0;
        end else begin
          beat_cnt <= beat_cnt + 3'd1;
          n_q      <= n_ins;
        end
      end
      if (state == SUM) out_q <= result;
    end
  end

endmodule

// File: tb/tb_smc_seq.sv
// Self-checking bench for smc_seq: frame-level model plus literal results.
module tb_smc_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  smc_seq_if bus ();

  smc_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int       m_vals[$];
  int       m_cnt   = 0;
  int       m_after = 0;
  bit [1:0] m_mode  = 2'b00;
  bit       m_valid = 1'b0;
  int       m_out   = 0;

  function automatic int beat_value(int w, int vgs, int vds, bit id);
    int gg;
    gg = (vgs == 0) ? 0 : vgs - 1;
    if (id) return (gg > vds) ? (w * vds * (2 * gg - vds)) / 3 : (w * gg * gg) / 3;
    else    return (gg > vds) ? (2 * w * vds) / 3 : (2 * w * gg) / 3;
  endfunction

  function automatic int frame_result();
    int s[$];
    int off;
    s = m_vals;
    s.rsort();
    off = m_mode[1] ? 0 : 3;
    if (m_mode[0]) return 3 * s[off] + 4 * s[off+1] + 5 * s[off+2];
    else           return s[off] + s[off+1] + s[off+2];
  endfunction

  // Frame view: six accepted beats, a one-cycle gap, one result cycle, then free.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_vals.delete();
        m_cnt = 0; m_after = 0; m_mode = 2'b00; m_valid = 1'b0; m_out = 0;
      end else begin
        m_valid = 1'b0;
        if (m_cnt == 6) begin
          m_after++;
          if (m_after == 1) begin
            m_valid = 1'b1;
            m_out   = frame_result();
          end else begin
            m_cnt = 0; m_after = 0;
            m_vals.delete();
          end
        end else if (bus.in_valid) begin
          if (m_cnt == 0) m_mode = bus.mode;
          m_vals.push_back(beat_value(int'(bus.W), int'(bus.V_GS), int'(bus.V_DS), m_mode[0]));
          m_cnt++;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int pulses   = 0;
  int last_out = 0;

  initial begin
    forever begin
      @(negedge clk);
      check("in_ready",  32'(bus.in_ready),  32'(m_cnt < 6));
      check("out_valid", 32'(bus.out_valid), 32'(m_valid));
      check("out_n",     32'(bus.out_n),     32'(m_out));
      if (bus.out_valid === 1'b1) begin
        pulses++;
        last_out = int'(bus.out_n);
      end
    end
  end

  // ---------------- stimulus ----------------
  int bw[6], bg[6], bd[6];

  task automatic set_ramp();
    for (int i = 0; i < 6; i++) begin bw[i] = i + 1; bg[i] = 2; bd[i] = 3; end
  endtask

  task automatic set_uniform(input int w, input int vgs, input int vds);
    for (int i = 0; i < 6; i++) begin bw[i] = w; bg[i] = vgs; bd[i] = vds; end
  endtask

  task automatic drive_beat(input int i, input logic [1:0] md);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.W    = 3'(bw[i]);
    bus.V_GS = 3'(bg[i]);
    bus.V_DS = 3'(bd[i]);
    bus.mode = (i == 0) ? md : ~md;
  endtask

  task automatic send_frame(input logic [1:0] md, input bit gaps, input bit hold);
    for (int i = 0; i < 6; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          bus.in_valid = 1'b0;
          bus.W = 3'($urandom); bus.V_GS = 3'($urandom); bus.V_DS = 3'($urandom);
          bus.mode = 2'($urandom);
        end
      end
      drive_beat(i, md);
    end
    if (hold) begin
      repeat (2) begin
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.W = 3'd7; bus.V_GS = 3'd7; bus.V_DS = 3'd0; bus.mode = ~md;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_frame(input string name, input logic [1:0] md, input bit gaps,
                           input bit hold, input int exp);
    int p0;
    p0 = pulses;
    send_frame(md, gaps, hold);
    for (int k = 0; k < 10 && pulses == p0; k++) begin
      @(negedge clk);
      #1;
    end
    repeat (2) @(negedge clk);
    #1;
    check({name, " pulses"}, 32'(pulses - p0), 32'd1);
    check({name, " result"}, 32'(last_out), 32'(exp));
  endtask

  initial begin
    int p0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.W = '0; bus.V_GS = '0; bus.V_DS = '0; bus.mode = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset in_ready",  32'(bus.in_ready),  32'd1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_n",     32'(bus.out_n),     32'd0);

    set_ramp();
    run_frame("gm largest",  2'd2, 1'b0, 1'b0, 9);
    run_frame("gm smallest", 2'd0, 1'b0, 1'b0, 3);
    run_frame("id largest",  2'd3, 1'b0, 1'b0, 15);
    run_frame("id smallest", 2'd1, 1'b0, 1'b0, 3);

    set_uniform(7, 7, 7);
    run_frame("id max", 2'd3, 1'b0, 1'b0, 1008);
    set_uniform(1, 3, 1);
    run_frame("id triode", 2'd3, 1'b0, 1'b0, 12);

    set_ramp();
    run_frame("gaps gm", 2'd2, 1'b1, 1'b1, 9);
    run_frame("gaps id", 2'd3, 1'b1, 1'b1, 15);

    // Abort a frame after beat 3; its result must never appear.
    p0 = pulses;
    for (int i = 0; i < 4; i++) drive_beat(i, 2'd3);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("abort out_n cleared", 32'(bus.out_n), 32'd0);
    check("abort in_ready",      32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("abort no strobe", 32'(pulses - p0), 32'd0);
    run_frame("after abort", 2'd2, 1'b0, 1'b0, 9);

    set_uniform(5, 0, 3);
    run_frame("vgs0 id", 2'd3, 1'b0, 1'b0, 0);
    set_uniform(7, 0, 0);
    run_frame("vgs0 gm", 2'd0, 1'b1, 1'b0, 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
